// File: rtl/axis_acc_feedback_buffer_pkg.sv
// axis_acc_pkg: FSM state type and last-bin helper shared by the accumulation buffer.
package axis_acc_pkg;

    typedef enum logic {ACCUM, DUMP} state_t;

    function automatic int bin_last(input int addr_width);
        return (1 << addr_width) - 1;
    endfunction

endpackage

// File: rtl/axis_acc_feedback_buffer_if.sv
// axis_acc_feedback_buffer_if: AXI-Stream style data/valid/ready/last bundle.
interface axis_acc_feedback_buffer_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_acc_feedback_buffer_ram.sv
// acc_sdp_ram: simple dual-port RAM, one write port and a registered read port.
module acc_sdp_ram #(
    parameter int WIDTH      = 64,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);
    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/axis_acc_feedback_buffer.sv
// axis_acc_feedback_buffer: per-bin accumulator memory feeding the adder, dumping bins after cfg_passes passes.
// Define ACC_FEEDBACK_TLAST_CHECK_EN to flag s_axis tlast misalignment in sts_error.
module axis_acc_feedback_buffer
    import axis_acc_pkg::*;
#(
    parameter int AXIS_TDATA_ACC_WIDTH = 64,
    parameter int ADDR_WIDTH           = 10,
    parameter int PASS_WIDTH           = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [PASS_WIDTH-1:0]       cfg_passes,
    axis_acc_feedback_buffer_if.slave   s_axis,
    axis_acc_feedback_buffer_if.master  m_axis_accin,
    axis_acc_feedback_buffer_if.master  m_axis_result,
    output logic [PASS_WIDTH-1:0]       sts_frames,
    output logic                        sts_error
);
    localparam logic [ADDR_WIDTH-1:0] BIN_END = ADDR_WIDTH'(bin_last(ADDR_WIDTH));

    state_t                          state, state_nxt;
    logic                            run;
    logic [ADDR_WIDTH-1:0]           bin_cnt, rd_addr;
    logic [PASS_WIDTH-1:0]           pass_cnt, passes_lat, pass_last;
    logic [AXIS_TDATA_ACC_WIDTH-1:0] rd_data;
    logic                            in_hs, out_hs, bin_end, frame_end;

    // run holds valid low for one cycle after reset while the bin 0 prefetch lands
    assign s_axis.tready        = run && state == ACCUM;
    assign m_axis_accin.tvalid  = run && state == ACCUM;
    assign m_axis_accin.tlast   = bin_end;
    assign m_axis_accin.tdata   = pass_cnt == '0 ? '0 : rd_data;
    assign m_axis_result.tvalid = state == DUMP;
    assign m_axis_result.tlast  = bin_end;
    assign m_axis_result.tdata  = rd_data;

    assign bin_end   = bin_cnt == BIN_END;
    assign in_hs     = s_axis.tvalid && s_axis.tready && m_axis_accin.tready;
    assign out_hs    = m_axis_result.tvalid && m_axis_result.tready;
    assign pass_last = passes_lat == '0 ? '0 : passes_lat - 1'b1;
    assign frame_end = in_hs && bin_end && pass_cnt == pass_last;

    always_comb begin
        state_nxt = state == ACCUM ? (frame_end ? DUMP : ACCUM) : (out_hs && bin_end ? ACCUM : DUMP);
        rd_addr   = in_hs || out_hs ? bin_cnt + 1'b1 : bin_cnt;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= ACCUM;
            run        <= 1'b0;
            bin_cnt    <= '0;
            pass_cnt   <= '0;
            passes_lat <= '0;
            sts_frames <= '0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
            if (in_hs || out_hs) bin_cnt <= bin_cnt + 1'b1;
            if (in_hs && bin_cnt == '0 && pass_cnt == '0) passes_lat <= cfg_passes;
            if (in_hs && bin_end) pass_cnt <= frame_end ? '0 : pass_cnt + 1'b1;
            if (out_hs && bin_end) sts_frames <= sts_frames + 1'b1;
        end
    end

    acc_sdp_ram #(
        .WIDTH      (AXIS_TDATA_ACC_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (aclk),
        .we    (in_hs && !areset),
        .waddr (bin_cnt),
        .wdata (s_axis.tdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

`ifdef ACC_FEEDBACK_TLAST_CHECK_EN
    always_ff @(posedge aclk) begin
        if (areset) sts_error <= 1'b0;
        else if (in_hs && s_axis.tlast != bin_end) sts_error <= 1'b1;
    end
`else
    logic unused_tlast;
    assign unused_tlast = s_axis.tlast;
    assign sts_error    = 1'b0;
`endif
endmodule

// File: tb/tb_axis_acc_feedback_buffer.sv
// tb_axis_acc_feedback_buffer: directed scenarios against a 4-bin, 3-pass buffer with an emulated adder.
module tb_axis_acc_feedback_buffer;
`ifdef ACC_FEEDBACK_TLAST_CHECK_EN
    localparam logic TLAST_CHK = 1'b1;
`else
    localparam logic TLAST_CHK = 1'b0;
`endif

    logic        aclk = 1'b0, areset = 1'b1;
    logic [15:0] cfg_passes = 16'd3;
    logic [15:0] sts_frames;
    logic        sts_error;
    logic        en = 1'b0, res_rdy = 1'b1, tag = 1'b0, tl_bad = 1'b0;
    logic [1:0]  hs_bin;
    int          errs = 0, checks = 0, cyc = 0;
    logic [63:0] acc_q[$], res_q[$];
    logic        accl_q[$], resl_q[$];
    int          acc_c[$];

    axis_acc_feedback_buffer_if #(.DATA_WIDTH(64)) s_if ();
    axis_acc_feedback_buffer_if #(.DATA_WIDTH(64)) acc_if ();
    axis_acc_feedback_buffer_if #(.DATA_WIDTH(64)) res_if ();

    axis_acc_feedback_buffer #(
        .AXIS_TDATA_ACC_WIDTH (64),
        .ADDR_WIDTH           (2),
        .PASS_WIDTH           (16)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_passes    (cfg_passes),
        .s_axis        (s_if),
        .m_axis_accin  (acc_if),
        .m_axis_result (res_if),
        .sts_frames    (sts_frames),
        .sts_error     (sts_error)
    );

    always #5 aclk = ~aclk;

    // combinational adder: accin + {1,2}; tag adds 16*bin to the low half so bins are distinguishable
    assign s_if.tvalid   = acc_if.tvalid && en;
    assign acc_if.tready = s_if.tready && en;
    assign s_if.tlast    = acc_if.tlast || (tl_bad && hs_bin == 2'd1);
    assign s_if.tdata    = {acc_if.tdata[63:32] + 32'd1,
                            acc_if.tdata[31:0] + 32'd2 + (tag ? 32'({hs_bin, 4'd0}) : 32'd0)};
    assign res_if.tready = res_rdy;

    always @(posedge aclk)
        if (areset) hs_bin <= 2'd0;
        else if (acc_if.tvalid && acc_if.tready) hs_bin <= hs_bin + 2'd1;

    always @(negedge aclk) begin
        cyc++;
        if (!areset) begin
            if (acc_if.tvalid && acc_if.tready) begin
                acc_q.push_back(acc_if.tdata);
                accl_q.push_back(acc_if.tlast);
                acc_c.push_back(cyc);
            end
            if (res_if.tvalid && res_if.tready) begin
                res_q.push_back(res_if.tdata);
                resl_q.push_back(res_if.tlast);
            end
        end
    end

    task automatic do_reset();
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1;
        do_reset();
        checks++; if (acc_if.tvalid !== 1'b0) begin errs++; $display("FAIL reset_accin_valid got %b want 0", acc_if.tvalid); end
        checks++; if (res_if.tvalid !== 1'b0) begin errs++; $display("FAIL reset_result_valid got %b want 0", res_if.tvalid); end
        checks++; if (s_if.tready !== 1'b0) begin errs++; $display("FAIL reset_s_ready got %b want 0", s_if.tready); end
        checks++; if (sts_frames !== 16'd0) begin errs++; $display("FAIL reset_frames got %0d want 0", sts_frames); end
        checks++; if (sts_error !== 1'b0) begin errs++; $display("FAIL reset_error got %b want 0", sts_error); end
        @(posedge aclk); #1;
        checks++; if (acc_if.tvalid !== 1'b1 || acc_if.tdata !== 64'd0) begin errs++; $display("FAIL reset_first_accin got v=%b d=%h want v=1 d=0", acc_if.tvalid, acc_if.tdata); end
    endtask

    task automatic test_full_frame();
        int ab, rb, snap;
        logic [63:0] exp;
        cfg_passes = 16'd3; en = 1'b1; res_rdy = 1'b1; tag = 1'b0;
        do_reset();
        ab = acc_q.size(); rb = res_q.size(); snap = -1;
        for (int i = 0; i < 200 && res_q.size() < rb + 4; i++) begin
            @(posedge aclk); #1;
            if (snap < 0 && res_q.size() >= rb + 1) snap = acc_q.size() - ab;
        end
        checks++; if (res_q.size() !== rb + 4) begin errs++; $display("FAIL full_result_count got %0d want 4", res_q.size() - rb); end
        checks++; if (snap !== 12) begin errs++; $display("FAIL full_accin_count got %0d want 12", snap); end
        checks++; if (acc_c[ab+11] - acc_c[ab] !== 11) begin errs++; $display("FAIL full_back_to_back got %0d cycles want 11", acc_c[ab+11] - acc_c[ab]); end
        for (int i = 0; i < 12; i++) begin
            exp = {32'(i / 4), 32'(2 * (i / 4))};
            checks++; if (acc_q[ab+i] !== exp || accl_q[ab+i] !== (i % 4 == 3)) begin
                errs++; $display("FAIL full_accin[%0d] got %h/%b want %h/%b", i, acc_q[ab+i], accl_q[ab+i], exp, i % 4 == 3);
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++; if (res_q[rb+k] !== {32'd3, 32'd6} || resl_q[rb+k] !== (k == 3)) begin
                errs++; $display("FAIL full_result[%0d] got %h/%b want %h/%b", k, res_q[rb+k], resl_q[rb+k], {32'd3, 32'd6}, k == 3);
            end
        end
        checks++; if (sts_frames !== 16'd1) begin errs++; $display("FAIL full_frames got %0d want 1", sts_frames); end
        checks++; if (acc_if.tvalid !== 1'b1 || acc_if.tdata !== 64'd0 || res_if.tvalid !== 1'b0) begin
            errs++; $display("FAIL full_restart got av=%b ad=%h rv=%b want 1 0 0", acc_if.tvalid, acc_if.tdata, res_if.tvalid);
        end
    endtask

    task automatic test_backpressure();
        int rb;
        logic [63:0] exp;
        cfg_passes = 16'd3; en = 1'b1; res_rdy = 1'b1; tag = 1'b1;
        do_reset();
        rb = res_q.size();
        for (int i = 0; i < 200 && res_q.size() < rb + 2; i++) begin @(posedge aclk); #1; end
        res_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge aclk); #1;
            checks++; if (res_if.tvalid !== 1'b1 || res_if.tdata !== {32'd3, 32'd102}) begin
                errs++; $display("FAIL bp_hold[%0d] got v=%b d=%h want v=1 d=%h", c, res_if.tvalid, res_if.tdata, {32'd3, 32'd102});
            end
        end
        res_rdy = 1'b1;
        for (int i = 0; i < 50 && res_q.size() < rb + 4; i++) begin @(posedge aclk); #1; end
        checks++; if (res_q.size() !== rb + 4) begin errs++; $display("FAIL bp_result_count got %0d want 4", res_q.size() - rb); end
        for (int k = 0; k < 4; k++) begin
            exp = {32'd3, 32'(6 + 48 * k)};
            checks++; if (res_q[rb+k] !== exp || resl_q[rb+k] !== (k == 3)) begin
                errs++; $display("FAIL bp_result[%0d] got %h/%b want %h/%b", k, res_q[rb+k], resl_q[rb+k], exp, k == 3);
            end
        end
        tag = 1'b0;
    endtask

    task automatic test_source_stall();
        int ab, rb;
        cfg_passes = 16'd3; en = 1'b0; res_rdy = 1'b1;
        do_reset();
        ab = acc_q.size(); rb = res_q.size();
        for (int i = 0; i < 400 && res_q.size() < rb + 4; i++) begin
            en = ~en;
            @(posedge aclk); #1;
        end
        en = 1'b1;
        checks++; if (res_q.size() !== rb + 4) begin errs++; $display("FAIL stall_result_count got %0d want 4", res_q.size() - rb); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (acc_q[ab+k] !== 64'd0) begin errs++; $display("FAIL stall_pass0[%0d] got %h want 0", k, acc_q[ab+k]); end
            checks++; if (res_q[rb+k] !== {32'd3, 32'd6} || resl_q[rb+k] !== (k == 3)) begin
                errs++; $display("FAIL stall_result[%0d] got %h/%b want %h/%b", k, res_q[rb+k], resl_q[rb+k], {32'd3, 32'd6}, k == 3);
            end
        end
        checks++; if (sts_frames !== 16'd1) begin errs++; $display("FAIL stall_frames got %0d want 1", sts_frames); end
    endtask

    task automatic test_zero_passes();
        int ab, rb, snap;
        cfg_passes = 16'd0; en = 1'b1; res_rdy = 1'b1;
        do_reset();
        ab = acc_q.size(); rb = res_q.size(); snap = -1;
        for (int i = 0; i < 100 && res_q.size() < rb + 4; i++) begin
            @(posedge aclk); #1;
            if (snap < 0 && res_q.size() >= rb + 1) snap = acc_q.size() - ab;
        end
        checks++; if (snap !== 4) begin errs++; $display("FAIL zero_accin_count got %0d want 4", snap); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (res_q[rb+k] !== {32'd1, 32'd2} || resl_q[rb+k] !== (k == 3)) begin
                errs++; $display("FAIL zero_result[%0d] got %h/%b want %h/%b", k, res_q[rb+k], resl_q[rb+k], {32'd1, 32'd2}, k == 3);
            end
        end
        cfg_passes = 16'd3;
    endtask

    task automatic test_reset_mid_pass();
        int ab;
        cfg_passes = 16'd3; en = 1'b1; res_rdy = 1'b1;
        do_reset();
        ab = acc_q.size();
        for (int i = 0; i < 100 && acc_q.size() < ab + 6; i++) begin @(posedge aclk); #1; end
        checks++; if (acc_if.tdata !== {32'd1, 32'd2}) begin errs++; $display("FAIL mid_pass1_bin2 got %h want %h", acc_if.tdata, {32'd1, 32'd2}); end
        do_reset();
        checks++; if (acc_if.tvalid !== 1'b0 || res_if.tvalid !== 1'b0) begin
            errs++; $display("FAIL mid_valids got accin=%b result=%b want 0 0", acc_if.tvalid, res_if.tvalid);
        end
        ab = acc_q.size();
        for (int i = 0; i < 100 && acc_q.size() < ab + 4; i++) begin @(posedge aclk); #1; end
        for (int k = 0; k < 4; k++) begin
            checks++; if (acc_q[ab+k] !== 64'd0 || accl_q[ab+k] !== (k == 3)) begin
                errs++; $display("FAIL mid_restart[%0d] got %h/%b want 0/%b", k, acc_q[ab+k], accl_q[ab+k], k == 3);
            end
        end
    endtask

    task automatic test_tlast_check();
        int ab, rb;
        cfg_passes = 16'd3; en = 1'b1; res_rdy = 1'b1; tl_bad = 1'b1;
        do_reset();
        ab = acc_q.size(); rb = res_q.size();
        for (int i = 0; i < 50 && acc_q.size() < ab + 1; i++) begin @(posedge aclk); #1; end
        checks++; if (sts_error !== 1'b0) begin errs++; $display("FAIL tlast_before got %b want 0", sts_error); end
        @(posedge aclk); #1;
        checks++; if (sts_error !== TLAST_CHK) begin errs++; $display("FAIL tlast_set got %b want %b", sts_error, TLAST_CHK); end
        tl_bad = 1'b0;
        for (int i = 0; i < 200 && res_q.size() < rb + 4; i++) begin @(posedge aclk); #1; end
        checks++; if (sts_error !== TLAST_CHK) begin errs++; $display("FAIL tlast_sticky got %b want %b", sts_error, TLAST_CHK); end
        checks++; if (res_q[rb] !== {32'd3, 32'd6}) begin errs++; $display("FAIL tlast_data got %h want %h", res_q[rb], {32'd3, 32'd6}); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_source_stall();
        test_zero_passes();
        test_reset_mid_pass();
        test_tlast_check();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
